rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- Round-robin arbiter granting one shared resource (e.g. memory/IO bus port) to one of 8 requesters.
- Sits between requesting units and the shared datapath.
- Grant is held until the owner releases it.
- Fairness via rotating priority pointer.
- Request-present detection uses the 8-input OR-reduction gate (Or8Way).

Parameters:
- HOLD_MAX, 16, maximum grant length in cycles when timeout is compiled in; legal range 1..255; ignored otherwise.
- CNT_W, 8, width of hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  8  request vector; bit i = requester i wants the resource; held high for the whole transaction
- grant  output  8  one-hot grant vector, registered; all-zero when idle
- grant_id  output  3  index of current owner; 0 when idle
- busy  output  1  high while any grant is active
- any_req  output  1  combinational OR of req[7:0]

Behaviour:
- Single clock clk; reset is synchronous, active-high, sampled on rising edge of clk.
- Reset values: grant=8'h00, grant_id=0, busy=0, ptr=0, state=IDLE, hold counter=0. any_req is combinational and unaffected.
- State encoding: IDLE, GRANT.
- IDLE:
  - If any_req=1, select first i with req[i]=1 searching ptr, ptr+1, ..., ptr+7 (mod 8).
  - Register grant=1<<i, grant_id=i, busy=1; go to GRANT.
  - Latency: req sampled high at edge N -> grant visible after edge N (one cycle from request).
- GRANT:
  - While req[grant_id]=1, hold grant unchanged; other requests are ignored.
  - Release: when req[grant_id]=0 is sampled, clear grant/grant_id/busy, set ptr=(grant_id+1) mod 8, go to IDLE.
  - Exactly one dead cycle between consecutive owners; no back-to-back handover.
- Pointer wrap: owner 7 releases -> ptr=0.
- Simultaneous events:
  - Release and new requests in the same cycle: release wins; new arbitration next cycle uses the updated ptr.
  - Multiple requests in IDLE: exactly one grant, highest rotating priority.
- Owner dropping and re-raising req: treated as a new request, subject to rotation.
- Reset mid-GRANT: grant removed at that edge; ptr back to 0.
- grant is always one-hot or zero; never more than one bit set.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Hold counter clears on entry to GRANT and increments each GRANT cycle.
  - After grant has been high for HOLD_MAX cycles, force release even if req still high: grant=0, ptr=(grant_id+1) mod 8, go to IDLE.
  - That requester then has lowest priority.
- Undefined: counter and compare logic absent; grant held indefinitely; HOLD_MAX unused.

Decomposition:
- Package arb_pkg:
  - NREQ=8, ID_W=3.
  - State encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
  - Default HOLD_MAX constant.
- Sub-module rr_pick8:
  - Combinational rotating-priority encoder.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: valid, id[2:0].
  - Rotate, priority-encode, un-rotate.
- any_req instantiates the existing 8-way OR gate.

Test Plan:
- Reset with req=8'hFF -> grant=0, busy=0 during reset; first edge after reset released -> grant=8'h01, grant_id=0.
- req=8'h24 from IDLE, ptr=0 -> grant=8'h04; drop req[2] -> one idle cycle -> grant=8'h20, grant_id=5.
- req=8'hFF held, each owner releases after 2 cycles -> grant order 0,1,...,7,0; pointer wraps from 7 to 0.
- Assert reset while grant=8'h08 -> grant=0, ptr=0 next edge; then req=8'h09 -> grant=8'h01.
- ARB_TIMEOUT_EN, HOLD_MAX=4, req=8'h03 constant -> grant 8'h01 for 4 cycles, 1 idle cycle, 8'h02 for 4 cycles, repeat.
- Without macro, req=8'h03 constant for 100 cycles -> grant stays 8'h01 throughout.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned NREQ         = 8;
    localparam int unsigned ID_W         = 3;
    localparam int unsigned HOLD_MAX_DEF = 16;
    localparam int unsigned CNT_W_DEF    = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // One-hot vector with only the bit for requester id set.
    function automatic logic [NREQ-1:0] id2onehot(input logic [ID_W-1:0] id);
        return NREQ'(1) << id;
    endfunction

endpackage

// File: rtl/Or8Way.sv
// 8-input OR-reduction gate shared across the codebase.
module Or8Way (
    input  logic [7:0] in,
    output logic       out
);

    assign out = |in;

endmodule

// File: rtl/rr_pick8.sv
// Combinational rotating-priority encoder: the first set request at or after ptr wins.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    logic [NREQ-1:0] rot;
    logic [ID_W-1:0] off;

    // Rotate so ptr lands on bit 0, find the lowest set bit, then rotate the index back.
    always_comb begin
        rot   = NREQ'({req, req} >> ptr);
        off   = '0;
        valid = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off   = ID_W'(i);
                valid = 1'b1;
            end
        end
        id = off + ptr;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for one shared resource across 8 requesters; the owner keeps the grant until release.
// Define ARB_TIMEOUT_EN to force release after HOLD_MAX grant cycles.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = HOLD_MAX_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_id,
    output logic            busy,
    output logic            any_req
);

    if (HOLD_MAX < 1 || HOLD_MAX > 255 || (64'(1) << CNT_W) <= 64'(HOLD_MAX)) begin : g_bad_cfg
        $error("rr_arbiter8: HOLD_MAX must be 1..255 and fit in CNT_W bits");
    end

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic            pick_valid;
    logic [ID_W-1:0] pick_id;
    logic            release_c;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;
`endif

    Or8Way u_or8 (
        .in  (req),
        .out (any_req)
    );

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .id    (pick_id)
    );

    // Owner gives up the resource by dropping its request, or by hitting the hold limit.
    always_comb begin
        release_c = !req[grant_id];
`ifdef ARB_TIMEOUT_EN
        if (hold_cnt == CNT_W'(HOLD_MAX - 1)) begin
            release_c = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req && pick_valid) begin
                        state    <= ST_GRANT;
                        grant    <= id2onehot(pick_id);
                        grant_id <= pick_id;
                        busy     <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                ST_GRANT: begin
                    // Releasing always costs one idle cycle; new arbitration uses the advanced pointer.
                    if (release_c) begin
                        state    <= ST_IDLE;
                        grant    <= '0;
                        grant_id <= '0;
                        busy     <= 1'b0;
                        ptr      <= grant_id + ID_W'(1);
                    end
`ifdef ARB_TIMEOUT_EN
                    else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: a behavioural model fills a scoreboard each cycle, plus directed checks.
module tb_rr_arbiter8;
    import arb_pkg::*;

    localparam int unsigned HOLD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       busy;
    logic       any_req;

    always #5 clk = ~clk;

    rr_arbiter8 #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .any_req  (any_req)
    );

    typedef struct packed {
        logic [7:0] grant;
        logic [2:0] id;
        logic       busy;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic       m_busy  = 1'b0;
    logic [2:0] m_ptr   = 3'd0;
    logic [2:0] m_id    = 3'd0;
    logic [7:0] m_grant = 8'h00;
    int         m_cnt   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Reference behaviour for one rising edge, pushing the expected post-edge outputs.
    task automatic model_step(input logic [7:0] r, input logic rst);
        logic rel;
        int   idx;
        if (rst) begin
            m_busy = 1'b0; m_ptr = 3'd0; m_id = 3'd0; m_grant = 8'h00; m_cnt = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < 8; k++) begin
                idx = (int'(m_ptr) + k) % 8;
                if (r[idx]) begin
                    m_busy  = 1'b1;
                    m_id    = 3'(idx);
                    m_grant = 8'(1) << idx;
                    m_cnt   = 0;
                    break;
                end
            end
        end else begin
            rel = !r[m_id];
`ifdef ARB_TIMEOUT_EN
            if (m_cnt == int'(HOLD) - 1) rel = 1'b1;
`endif
            if (rel) begin
                m_busy = 1'b0; m_grant = 8'h00; m_ptr = m_id + 3'd1; m_id = 3'd0;
            end else begin
                m_cnt++;
            end
        end
        sb_q.push_back('{m_grant, m_id, m_busy});
    endtask

    task automatic step(input logic [7:0] r, input logic rst, input string tag);
        exp_t e;
        @(negedge clk);
        req   = r;
        reset = rst;
        #1;
        check({tag, "/any_req"}, 32'(any_req), 32'(|r));
        model_step(r, rst);
        @(posedge clk);
        #1;
        check({tag, "/sb_depth"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "/grant"},    32'(grant),    32'(e.grant));
            check({tag, "/grant_id"}, 32'(grant_id), 32'(e.id));
            check({tag, "/busy"},     32'(busy),     32'(e.busy));
        end
        check({tag, "/onehot0"}, 32'($onehot0(grant)), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] cur;
        logic [7:0] exp_g;

        // Reset with everyone requesting, then first edge after reset.
        step(8'hFF, 1'b1, "rst0");
        step(8'hFF, 1'b1, "rst1");
        check("rst/grant", 32'(grant), 32'h00);
        check("rst/busy",  32'(busy),  32'd0);
        step(8'hFF, 1'b0, "rst_rel");
        check("rst_rel/grant",    32'(grant),    32'h01);
        check("rst_rel/grant_id", 32'(grant_id), 32'd0);
        step(8'h00, 1'b0, "rst_drop");

        // 0x24 from ptr 0: owner 2, then one idle cycle, then owner 5.
        step(8'h00, 1'b1, "t2_rst");
        step(8'h24, 1'b0, "t2_a");
        check("t2/first", 32'(grant), 32'h04);
        step(8'h24, 1'b0, "t2_hold");
        check("t2/hold", 32'(grant), 32'h04);
        step(8'h20, 1'b0, "t2_rel");
        check("t2/dead", 32'(grant), 32'h00);
        step(8'h20, 1'b0, "t2_b");
        check("t2/second",    32'(grant),    32'h20);
        check("t2/second_id", 32'(grant_id), 32'd5);
        step(8'h00, 1'b0, "t2_end");

        // All requesting, each owner drops after two grant cycles; order 0..7 then wraps to 0.
        step(8'h00, 1'b1, "t3_rst");
        for (int o = 0; o < 9; o++) begin
            step(8'hFF, 1'b0, "t3_win");
            exp_g = 8'(1) << (o % 8);
            check($sformatf("t3/order%0d", o), 32'(grant), 32'(exp_g));
            step(8'hFF, 1'b0, "t3_hold");
            step(8'hFF & ~exp_g, 1'b0, "t3_rel");
        end

        // Reset while owner 3 holds; pointer returns to 0.
        step(8'h00, 1'b1, "t4_rst");
        step(8'h08, 1'b0, "t4_a");
        check("t4/owner3", 32'(grant), 32'h08);
        step(8'h08, 1'b1, "t4_midrst");
        check("t4/cleared", 32'(grant), 32'h00);
        step(8'h09, 1'b0, "t4_b");
        check("t4/ptr0", 32'(grant), 32'h01);

        // Constant 0x03 for 100 cycles: held forever, or rotated by the hold limit.
        step(8'h00, 1'b1, "t5_rst");
        for (int k = 0; k < 100; k++) begin
            step(8'h03, 1'b0, "t5");
`ifdef ARB_TIMEOUT_EN
            exp_g = (k % 5 == 4) ? 8'h00 : (((k / 5) % 2) != 0 ? 8'h02 : 8'h01);
`else
            exp_g = 8'h01;
`endif
            check($sformatf("t5/cyc%0d", k), 32'(grant), 32'(exp_g));
        end

        // Random traffic with mostly stable requests and occasional resets.
        cur = 8'h00;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) cur = 8'($urandom);
            step(cur, ($urandom_range(0, 49) == 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
